// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-side consumer for the async FIFO (read clock domain).
// Pops the FIFO in threshold-triggered bursts or on flush and delivers the
// words on a valid/ready stream through a 2-entry buffer that absorbs the
// one-cycle FIFO read latency.
//
// Ports:
//   rclk, sw_rst          read clock, synchronous active-high reset
//   enable                allow new bursts/flushes to start
//   burst_thresh          start a burst when rd_level >= burst_thresh
//   burst_len             words per burst (0 acts as 1), sampled at start
//   flush                 request a drain until the FIFO is empty
//   rdempty, rd_level     FIFO read-side status
//   read_data, underflow  FIFO data (1 cycle after read_enable), status
//   read_enable           FIFO pop
//   m_data/m_valid/m_ready output stream
//   busy                  operation active or buffer holds data
//   burst_done/flush_done 1-cycle completion pulses
//   word_count            words delivered, wraps at 2^32
//   underflow_err         sticky underflow flag
module fifo_rd_drain #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                   rclk,
    input  logic                   sw_rst,
    input  logic                   enable,
    input  logic [ADDRESS_WIDTH:0] burst_thresh,
    input  logic [ADDRESS_WIDTH:0] burst_len,
    input  logic                   flush,
    input  logic                   rdempty,
    input  logic [ADDRESS_WIDTH:0] rd_level,
    input  logic [DATA_WIDTH-1:0]  read_data,
    input  logic                   underflow,
    output logic                   read_enable,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy,
    output logic                   burst_done,
    output logic                   flush_done,
    output logic [31:0]            word_count,
    output logic                   underflow_err
);

    localparam int LW = ADDRESS_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        BURST,
        FLUSH
    } state_t;

    state_t state, state_nx;

    logic [LW-1:0]         issue_rem;
    logic [LW-1:0]         deliver_rem;
    logic [LW-1:0]         len_eff;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;
    logic                  flush_pending;
    logic                  pop;
    logic [2:0]            fill_after;
    logic                  start_burst;
    logic                  burst_end;
    logic                  flush_end;

    assign pop     = m_valid && m_ready;
    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_q[rd_ptr];
    assign len_eff = (burst_len == '0) ? LW'(1) : burst_len;
    assign busy    = (state == BURST) || (state == FLUSH) || (occ != 2'd0);

    // Buffer fill once the word in flight lands and the current pop leaves.
    // A pop implies occ >= 1, so this never goes negative.
    assign fill_after = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    always_comb begin
        state_nx    = state;
        read_enable = 1'b0;
        start_burst = 1'b0;
        burst_end   = 1'b0;
        flush_end   = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else if (flush_pending) begin
                    state_nx = FLUSH;
                end else if (rd_level >= burst_thresh) begin
                    state_nx    = BURST;
                    start_burst = 1'b1;
                end
            end
            BURST: begin
                read_enable = !rdempty
                           && (issue_rem != '0)
                           && (fill_after < 3'd2);
                if (pop && (deliver_rem == LW'(1))) begin
                    burst_end = 1'b1;
                    state_nx  = enable ? ARMED : IDLE;
                end
            end
            FLUSH: begin
                read_enable = !rdempty && (fill_after < 3'd2);
                if (rdempty && !inflight && (occ == 2'd0)) begin
                    flush_end = 1'b1;
                    state_nx  = enable ? ARMED : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (sw_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge rclk) begin
        if (sw_rst) begin
            issue_rem   <= '0;
            deliver_rem <= '0;
        end else if (start_burst) begin
            issue_rem   <= len_eff;
            deliver_rem <= len_eff;
        end else if (state == BURST) begin
            if (read_enable) begin
                issue_rem <= issue_rem - LW'(1);
            end
            if (pop) begin
                deliver_rem <= deliver_rem - LW'(1);
            end
        end
    end

    // Reset drops a word still in flight: inflight clears, so the
    // read_data that follows is never captured.
    always_ff @(posedge rclk) begin
        if (sw_rst) begin
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            inflight <= read_enable;
            if (inflight) begin
                buf_q[wr_ptr] <= read_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= fill_after[1:0];
        end
    end

    always_ff @(posedge rclk) begin
        if (sw_rst) begin
            flush_pending <= 1'b0;
        end else if (flush_end) begin
            flush_pending <= 1'b0;
        end else if (flush && (state != IDLE)) begin
            flush_pending <= 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (sw_rst) begin
            burst_done    <= 1'b0;
            flush_done    <= 1'b0;
            word_count    <= '0;
            underflow_err <= 1'b0;
        end else begin
            burst_done    <= burst_end;
            flush_done    <= flush_end;
            word_count    <= word_count + 32'(pop);
            underflow_err <= underflow_err | underflow;
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: scenario bench for fifo_rd_drain with a queue-based
// FIFO source model and an in-order delivery scoreboard.
module tb_fifo_rd_drain;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LW = AW + 1;

    logic          rclk = 1'b0;
    logic          sw_rst, enable, flush, rdempty, underflow, m_ready;
    logic [LW-1:0] burst_thresh, burst_len, rd_level;
    logic [DW-1:0] read_data;
    logic          read_enable, m_valid, busy;
    logic          burst_done, flush_done, underflow_err;
    logic [DW-1:0] m_data;
    logic [31:0]   word_count;

    fifo_rd_drain #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .rclk          (rclk),
        .sw_rst        (sw_rst),
        .enable        (enable),
        .burst_thresh  (burst_thresh),
        .burst_len     (burst_len),
        .flush         (flush),
        .rdempty       (rdempty),
        .rd_level      (rd_level),
        .read_data     (read_data),
        .underflow     (underflow),
        .read_enable   (read_enable),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .busy          (busy),
        .burst_done    (burst_done),
        .flush_done    (flush_done),
        .word_count    (word_count),
        .underflow_err (underflow_err)
    );

    always #5 rclk = ~rclk;

    int n_cmp, n_fail;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int re_cyc[$];
    int cyc, re_cnt, re_empty, bd_cnt, fd_cnt, stab_err;
    int pop_cyc, bd_cyc;
    logic hold_v;
    logic [DW-1:0] hold_d;

    task automatic upd_lvl();
        rdempty  = (fq.size() == 0);
        rd_level = LW'(fq.size());
    endtask

    task automatic write_words(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            fq.push_back(w);
            exp_q.push_back(w);
        end
        upd_lvl();
    endtask

    task automatic clear_stats();
        re_cyc.delete();
        got_q.delete();
        re_cnt   = 0;
        re_empty = 0;
        bd_cnt   = 0;
        fd_cnt   = 0;
        stab_err = 0;
        hold_v   = 1'b0;
    endtask

    // One clock: observe at negedge, then advance the FIFO model.
    task automatic step();
        logic re;
        @(negedge rclk);
        cyc++;
        re = read_enable;
        if (re) begin
            re_cnt++;
            re_cyc.push_back(cyc);
            if (rdempty) re_empty++;
        end
        if (hold_v && (!m_valid || m_data !== hold_d)) stab_err++;
        hold_v = m_valid && !m_ready;
        hold_d = m_data;
        if (m_valid && m_ready) begin
            got_q.push_back(m_data);
            pop_cyc = cyc;
        end
        if (burst_done) begin
            bd_cnt++;
            bd_cyc = cyc;
        end
        if (flush_done) fd_cnt++;
        @(posedge rclk);
        #1;
        if (re && fq.size() > 0) read_data = fq.pop_front();
        upd_lvl();
        #1;
    endtask

    task automatic do_reset();
        sw_rst    = 1'b1;
        enable    = 1'b0;
        flush     = 1'b0;
        underflow = 1'b0;
        m_ready   = 1'b0;
        fq.delete();
        exp_q.delete();
        read_data = '0;
        upd_lvl();
        step();
        sw_rst = 1'b0;
        clear_stats();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (read_enable !== 1'b0) begin n_fail++; $display("FAIL rst_re: got %b want 0", read_enable); end
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", m_data); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (burst_done !== 1'b0) begin n_fail++; $display("FAIL rst_bd: got %b want 0", burst_done); end
        n_cmp++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL rst_fd: got %b want 0", flush_done); end
        n_cmp++; if (word_count !== 32'd0) begin n_fail++; $display("FAIL rst_wc: got %0d want 0", word_count); end
        n_cmp++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL rst_uf: got %b want 0", underflow_err); end
        enable       = 1'b1;
        burst_thresh = 6'd4;
        burst_len    = 6'd4;
        m_ready      = 1'b1;
        write_words(3);
        for (int i = 0; i < 10; i++) step();
        n_cmp++; if (re_cnt !== 0) begin n_fail++; $display("FAIL armed_noread: got %0d want 0", re_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL armed_busy: got %b want 0", busy); end
    endtask

    task automatic test_burst();
        int span;
        write_words(5);
        for (int i = 0; i < 40 && bd_cnt < 1; i++) step();
        span = (re_cyc.size() >= 4) ? re_cyc[3] - re_cyc[0] : -1;
        n_cmp++; if (bd_cnt !== 1) begin n_fail++; $display("FAIL burst_done: got %0d want 1", bd_cnt); end
        n_cmp++; if (re_cnt !== 4) begin n_fail++; $display("FAIL burst_reads: got %0d want 4", re_cnt); end
        n_cmp++; if (span !== 3) begin n_fail++; $display("FAIL burst_consec: got %0d want 3", span); end
        n_cmp++; if (bd_cyc !== pop_cyc + 1) begin n_fail++; $display("FAIL burst_bd_lat: got %0d want %0d", bd_cyc, pop_cyc + 1); end
        n_cmp++; if (word_count !== 32'd4) begin n_fail++; $display("FAIL burst_wc: got %0d want 4", word_count); end
        step();
        span = (re_cyc.size() >= 5) ? re_cyc[4] - bd_cyc : -1;
        n_cmp++; if (span !== 1) begin n_fail++; $display("FAIL burst_rearm: got %0d want 1", span); end
        n_cmp++; if (bd_cnt !== 1) begin n_fail++; $display("FAIL burst_pulse: got %0d want 1", bd_cnt); end
        for (int i = 0; i < 40 && bd_cnt < 2; i++) step();
        n_cmp++; if (bd_cnt !== 2) begin n_fail++; $display("FAIL burst2_done: got %0d want 2", bd_cnt); end
        n_cmp++; if (re_cnt !== 8) begin n_fail++; $display("FAIL burst2_reads: got %0d want 8", re_cnt); end
        n_cmp++; if (word_count !== 32'd8) begin n_fail++; $display("FAIL burst2_wc: got %0d want 8", word_count); end
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL burst_cnt: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        enable       = 1'b1;
        burst_thresh = 6'd4;
        burst_len    = 6'd8;
        write_words(8);
        for (int i = 0; i < 14; i++) step();
        n_cmp++; if (re_cnt !== 2) begin n_fail++; $display("FAIL bp_reads: got %0d want 2", re_cnt); end
        n_cmp++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", m_valid); end
        n_cmp++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL bp_early: got %0d want 0", got_q.size()); end
        m_ready = 1'b1;
        for (int i = 0; i < 40 && bd_cnt < 1; i++) step();
        n_cmp++; if (bd_cnt !== 1) begin n_fail++; $display("FAIL bp_done: got %0d want 1", bd_cnt); end
        n_cmp++; if (re_cnt !== 8) begin n_fail++; $display("FAIL bp_total: got %0d want 8", re_cnt); end
        n_cmp++; if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d want 0", stab_err); end
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_cnt: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_empty_stall();
        do_reset();
        enable       = 1'b1;
        burst_thresh = 6'd3;
        burst_len    = 6'd6;
        m_ready      = 1'b1;
        write_words(3);
        for (int i = 0; i < 15; i++) step();
        n_cmp++; if (re_cnt !== 3) begin n_fail++; $display("FAIL stall_reads: got %0d want 3", re_cnt); end
        n_cmp++; if (bd_cnt !== 0) begin n_fail++; $display("FAIL stall_done: got %0d want 0", bd_cnt); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b want 1", busy); end
        write_words(3);
        for (int i = 0; i < 40 && bd_cnt < 1; i++) step();
        step();
        step();
        n_cmp++; if (bd_cnt !== 1) begin n_fail++; $display("FAIL stall_end: got %0d want 1", bd_cnt); end
        n_cmp++; if (re_cnt !== 6) begin n_fail++; $display("FAIL stall_total: got %0d want 6", re_cnt); end
        n_cmp++; if (re_empty !== 0) begin n_fail++; $display("FAIL stall_re_empty: got %0d want 0", re_empty); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_idle: got %b want 0", busy); end
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_cnt: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_flush_mid_burst();
        do_reset();
        enable       = 1'b1;
        burst_thresh = 6'd4;
        burst_len    = 6'd8;
        m_ready      = 1'b1;
        write_words(12);
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 80 && fd_cnt < 1; i++) step();
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (bd_cnt !== 1) begin n_fail++; $display("FAIL fl_bd: got %0d want 1", bd_cnt); end
        n_cmp++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL fl_fd: got %0d want 1", fd_cnt); end
        n_cmp++; if (re_cnt !== 12) begin n_fail++; $display("FAIL fl_reads: got %0d want 12", re_cnt); end
        n_cmp++; if (word_count !== 32'd12) begin n_fail++; $display("FAIL fl_wc: got %0d want 12", word_count); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fl_busy: got %b want 0", busy); end
        n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL fl_cnt: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fl_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_len_zero();
        do_reset();
        enable       = 1'b1;
        burst_thresh = 6'd1;
        burst_len    = 6'd0;
        m_ready      = 1'b1;
        write_words(1);
        for (int i = 0; i < 30 && bd_cnt < 1; i++) step();
        n_cmp++; if (bd_cnt !== 1) begin n_fail++; $display("FAIL len0_done: got %0d want 1", bd_cnt); end
        n_cmp++; if (re_cnt !== 1) begin n_fail++; $display("FAIL len0_reads: got %0d want 1", re_cnt); end
        n_cmp++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL len0_cnt: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            n_cmp++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL len0_data: got %h want %h", got_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable       = 1'b1;
        burst_thresh = 6'd2;
        burst_len    = 6'd8;
        m_ready      = 1'b1;
        write_words(8);
        for (int i = 0; i < 20 && re_cnt < 1; i++) step();
        n_cmp++; if (re_cnt !== 1) begin n_fail++; $display("FAIL mid_started: got %0d want 1", re_cnt); end
        sw_rst = 1'b1;
        enable = 1'b0;
        step();
        sw_rst = 1'b0;
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", m_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_cmp++; if (read_enable !== 1'b0) begin n_fail++; $display("FAIL mid_re: got %b want 0", read_enable); end
        n_cmp++; if (word_count !== 32'd0) begin n_fail++; $display("FAIL mid_wc: got %0d want 0", word_count); end
        step();
        n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got %b want 0", m_valid); end
        n_cmp++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL uf_pre: got %b want 0", underflow_err); end
        underflow = 1'b1;
        step();
        underflow = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b want 1", underflow_err); end
        do_reset();
        n_cmp++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL uf_clear: got %b want 0", underflow_err); end
    endtask

    task automatic test_random();
        int fed, fd0;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            enable       = 1'b1;
            burst_thresh = LW'($urandom_range(1, 6));
            burst_len    = LW'($urandom_range(0, 7));
            for (int i = 0; i < 300; i++) begin
                m_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) == 0 && fq.size() < 40)
                    write_words($urandom_range(1, 3));
                flush = ($urandom_range(0, 49) == 0);
                step();
            end
            flush        = 1'b0;
            burst_thresh = '1;
            fed          = 0;
            for (int i = 0; i < 400 && busy; i++) begin
                m_ready = ($urandom_range(0, 3) != 0);
                if (rdempty && fed < 64) begin
                    write_words(1);
                    fed++;
                end
                step();
            end
            fd0   = fd_cnt;
            flush = 1'b1;
            step();
            flush = 1'b0;
            for (int i = 0; i < 400 && fd_cnt == fd0; i++) begin
                m_ready = ($urandom_range(0, 3) != 0);
                step();
            end
            step();
            step();
            n_cmp++; if (fd_cnt <= fd0) begin n_fail++; $display("FAIL rnd%0d_flush: got %0d want >%0d", r, fd_cnt, fd0); end
            n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_busy: got %b want 0", r, busy); end
            n_cmp++; if (re_empty !== 0) begin n_fail++; $display("FAIL rnd%0d_re_empty: got %0d want 0", r, re_empty); end
            n_cmp++; if (stab_err !== 0) begin n_fail++; $display("FAIL rnd%0d_stable: got %0d want 0", r, stab_err); end
            n_cmp++; if (word_count !== 32'(exp_q.size())) begin n_fail++; $display("FAIL rnd%0d_wc: got %0d want %0d", r, word_count, exp_q.size()); end
            n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_cnt: got %0d want %0d", r, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_data[%0d]: got %h want %h", r, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        cyc          = 0;
        pop_cyc      = 0;
        bd_cyc       = 0;
        sw_rst       = 1'b1;
        enable       = 1'b0;
        flush        = 1'b0;
        underflow    = 1'b0;
        m_ready      = 1'b0;
        burst_thresh = '0;
        burst_len    = '0;
        read_data    = '0;
        upd_lvl();
        clear_stats();
        test_reset();
        test_burst();
        test_backpressure();
        test_empty_stall();
        test_flush_mid_burst();
        test_len_zero();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
